pll_loop_backend: RTL and testbench
===================================

PLL_LOOP_BACKEND -- requirements
Module: pll_loop_backend

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 7: signed phase-error code width.
REQ-002 SHALL have parameter WIDTH_OUT, default 18: loop-filter and DAC code width.
REQ-003 SHALL have parameter DTC_WIDTH, default 10: DTC delay-code width.
REQ-004 SHALL have parameter KP, default 64: proportional gain, integer, at least 0.
REQ-005 SHALL have parameter KI, default 4: integral gain, integer, at least 0.
REQ-006 SHALL have port clk, input, 1 bit: single clock; everything is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port err_in, input, WIDTH_IN bits: signed two's-complement phase error, sampled every cycle.
REQ-009 SHALL have port freeze, input, 1 bit: while 1, the integrator holds its value.
REQ-010 SHALL have port qnc_in, input, DTC_WIDTH bits: signed quantisation-noise correction.
REQ-011 SHALL have port dlf_out, output, WIDTH_OUT bits: unsigned loop-filter code.
REQ-012 SHALL have port dac_p, output, WIDTH_OUT bits: positive differential DAC code.
REQ-013 SHALL have port dac_n, output, WIDTH_OUT bits: negative differential DAC code.
REQ-014 SHALL have port dtc_code, output, DTC_WIDTH bits: unsigned DTC tap select.

Function
REQ-015 SHALL keep a signed integrator acc of WIDTH_OUT+2 bits.
  - Each cycle with freeze=0: acc_next = acc + KI*err_in.
  - The result SHALL be clamped to the range [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1] (anti-windup).
REQ-016 SHALL compute sum = 2^(WIDTH_OUT-1) + acc_next + KP*err_in.
  - acc_next is the post-update value; it equals acc when freeze=1.
  - sum is saturated to [0, 2^WIDTH_OUT-1] and registered into dlf_out.
  - Latency: one cycle from err_in to dlf_out.
REQ-017 SHALL drive dac_p = dlf_out and dac_n = (2^WIDTH_OUT-1) - dlf_out combinationally from the register, with zero added latency.
  - Invariant: dac_p + dac_n = 2^WIDTH_OUT-1 always.
REQ-018 SHALL register dtc_code = qnc_in + 2^(DTC_WIDTH-1), an offset-binary conversion with no overflow possible.
  - Latency: one cycle.
REQ-019 SHALL perform all intermediate arithmetic signed, with at least WIDTH_OUT+8 bits, so products and sums never wrap before saturation.
REQ-020 SHALL treat freeze as affecting only the integral path; the proportional term continues to act.

Reset
REQ-021 SHALL, while rst=0, force these values regardless of clk:
  - acc = 0
  - dlf_out = 2^(WIDTH_OUT-1) (131072 at default width)
  - dac_p = 131072, dac_n = 131071
  - dtc_code = 2^(DTC_WIDTH-1) (512)
REQ-022 SHALL resume on the first rising clk after rst deasserts. Reset asserted mid-operation SHALL discard integrator state immediately.

Configuration
REQ-023 SHALL compile in the DTC correction path only when the macro PLL_BACKEND_DTC_EN is defined.
  - Without the macro, qnc_in is ignored, dtc_code is constant 2^(DTC_WIDTH-1), and no DTC register is built.

Structure
REQ-024 SHALL take default widths, default gains and the midscale constants from the shared package pll_backend_pkg.
REQ-025 SHALL implement the integrator/saturation datapath (REQ-015, REQ-016) as one sub-module, pll_backend_dlf_core.
REQ-026 SHALL keep the DAC mapping and DTC offset logic in the top module.

Verification
REQ-027 SHALL cover reset: rst=0 with random inputs -> dlf_out=131072, dac_n=131071, dtc_code=512.
REQ-028 SHALL cover a single error step:
  - Stimulus after reset: err_in=+1 for one cycle, then 0.
  - Required: dlf_out=131140, then 131076 and stays there.
  - dac_n=131003, then 131067.
REQ-029 SHALL cover freeze: err_in=-2 with freeze=1 from reset -> dlf_out=130944 constant (no integration).
REQ-030 SHALL cover saturation:
  - err_in=+63 held -> dlf_out reaches 262143 and holds, and acc clamps at 131071.
  - Then err_in=-63 -> dlf_out leaves saturation on the next cycle with no wrap.
REQ-031 SHALL cover DTC with PLL_BACKEND_DTC_EN defined:
  - qnc_in = -512, 0, +511 -> dtc_code = 0, 512, 1023, each one cycle later.
  - With the macro undefined -> dtc_code = 512 always.
REQ-032 SHALL cover reset mid-operation: rst pulses low while dlf_out=200000 -> outputs return immediately to midscale, and the next err_in=0 keeps dlf_out=131072.

Source files
------------

// File: rtl/pll_backend_pkg.sv
// Shared defaults for the PLL loop back-end: widths, loop gains and midscale helper.
package pll_backend_pkg;

    localparam int PLL_WIDTH_IN  = 7;
    localparam int PLL_WIDTH_OUT = 18;
    localparam int PLL_DTC_WIDTH = 10;
    localparam int PLL_KP        = 64;
    localparam int PLL_KI        = 4;

    // Offset-binary zero point of a w-bit code, i.e. 2^(w-1).
    function automatic int unsigned midscale(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/pll_backend_dlf_core.sv
// Digital loop filter: clamped PI integrator plus saturated unsigned output code.
module pll_backend_dlf_core
    import pll_backend_pkg::*;
#(
    parameter int WIDTH_IN  = PLL_WIDTH_IN,
    parameter int WIDTH_OUT = PLL_WIDTH_OUT,
    parameter int KP        = PLL_KP,
    parameter int KI        = PLL_KI
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [WIDTH_IN-1:0] err_in,
    input  logic                       freeze,
    output logic [WIDTH_OUT-1:0]       dlf_out
);

    // Wide enough that any 32-bit gain times the error plus the integrator cannot wrap.
    localparam int AW = WIDTH_OUT + WIDTH_IN + 34;

    localparam logic signed [AW-1:0] MID_W     = AW'(midscale(WIDTH_OUT));
    localparam logic signed [AW-1:0] DLF_MAX_W = (MID_W <<< 1) - 1;
    localparam logic signed [AW-1:0] ACC_HI_W  = MID_W - 1;
    localparam logic signed [AW-1:0] ACC_LO_W  = -MID_W;
    localparam logic signed [AW-1:0] KP_W      = AW'(KP);
    localparam logic signed [AW-1:0] KI_W      = AW'(KI);
    localparam logic [WIDTH_OUT-1:0] DLF_MID   = WIDTH_OUT'(midscale(WIDTH_OUT));

    logic signed [AW-1:0]        w_err;
    logic signed [AW-1:0]        w_acc_ext;
    logic signed [AW-1:0]        w_acc_sum;
    logic signed [AW-1:0]        w_sum;
    logic signed [WIDTH_OUT+1:0] w_acc_next;
    logic [WIDTH_OUT-1:0]        w_dlf_next;
    logic signed [WIDTH_OUT+1:0] r_acc;
    logic [WIDTH_OUT-1:0]        r_dlf;

    always_comb begin
        w_err     = AW'(err_in);
        w_acc_ext = AW'(r_acc);
        w_acc_sum = freeze ? w_acc_ext : (w_acc_ext + w_err * KI_W);

        if (w_acc_sum > ACC_HI_W)
            w_acc_next = ACC_HI_W[WIDTH_OUT+1:0];
        else if (w_acc_sum < ACC_LO_W)
            w_acc_next = ACC_LO_W[WIDTH_OUT+1:0];
        else
            w_acc_next = w_acc_sum[WIDTH_OUT+1:0];

        // Proportional path uses the post-update integrator and ignores freeze.
        w_sum = MID_W + AW'(w_acc_next) + w_err * KP_W;

        if (w_sum[AW-1])
            w_dlf_next = '0;
        else if (w_sum > DLF_MAX_W)
            w_dlf_next = '1;
        else
            w_dlf_next = w_sum[WIDTH_OUT-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_dlf <= DLF_MID;
        end else begin
            r_acc <= w_acc_next;
            r_dlf <= w_dlf_next;
        end
    end

    assign dlf_out = r_dlf;

endmodule

// File: rtl/pll_loop_backend.sv
// PLL loop back-end: loop filter, differential DAC mapping and DTC offset code.
// Define PLL_BACKEND_DTC_EN to build the registered DTC correction path.
module pll_loop_backend
    import pll_backend_pkg::*;
#(
    parameter int WIDTH_IN  = PLL_WIDTH_IN,
    parameter int WIDTH_OUT = PLL_WIDTH_OUT,
    parameter int DTC_WIDTH = PLL_DTC_WIDTH,
    parameter int KP        = PLL_KP,
    parameter int KI        = PLL_KI
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [WIDTH_IN-1:0]  err_in,
    input  logic                        freeze,
    input  logic signed [DTC_WIDTH-1:0] qnc_in,
    output logic [WIDTH_OUT-1:0]        dlf_out,
    output logic [WIDTH_OUT-1:0]        dac_p,
    output logic [WIDTH_OUT-1:0]        dac_n,
    output logic [DTC_WIDTH-1:0]        dtc_code
);

    localparam logic [WIDTH_OUT-1:0] DAC_FS  = '1;
    localparam logic [DTC_WIDTH-1:0] DTC_MID = DTC_WIDTH'(midscale(DTC_WIDTH));

    pll_backend_dlf_core #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .KP        (KP),
        .KI        (KI)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .err_in  (err_in),
        .freeze  (freeze),
        .dlf_out (dlf_out)
    );

    assign dac_p = dlf_out;
    assign dac_n = DAC_FS - dlf_out;

`ifdef PLL_BACKEND_DTC_EN
    logic [DTC_WIDTH-1:0] r_dtc;

    // Adding 2^(DTC_WIDTH-1) to a two's-complement code is just an MSB flip.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_dtc <= DTC_MID;
        else
            r_dtc <= {~qnc_in[DTC_WIDTH-1], qnc_in[DTC_WIDTH-2:0]};
    end

    assign dtc_code = r_dtc;
`else
    logic w_unused_qnc;

    assign w_unused_qnc = ^qnc_in;
    assign dtc_code     = DTC_MID;
`endif

endmodule

// File: tb/tb_pll_loop_backend.sv
// Directed self-checking bench for pll_loop_backend at default parameters.
module tb_pll_loop_backend;

    logic               clk;
    logic               rst;
    logic signed [6:0]  err;
    logic               freeze;
    logic signed [9:0]  qnc;
    logic [17:0]        dlf_out;
    logic [17:0]        dac_p;
    logic [17:0]        dac_n;
    logic [9:0]         dtc_code;

    int n_tests;
    int n_fail;
    int n;

    pll_loop_backend dut (
        .clk      (clk),
        .rst      (rst),
        .err_in   (err),
        .freeze   (freeze),
        .qnc_in   (qnc),
        .dlf_out  (dlf_out),
        .dac_p    (dac_p),
        .dac_n    (dac_n),
        .dtc_code (dtc_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        freeze  = 1'b0;
        err     = 7'sd0;
        qnc     = 10'sd0;

        // Reset held with random inputs, checked before and across clock edges
        #1;
        rst    = 1'b0;
        err    = 7'($urandom);
        qnc    = 10'($urandom);
        freeze = 1'($urandom);
        #1;
        check_eq("rst_dlf", dlf_out, 131072);
        check_eq("rst_dac_p", dac_p, 131072);
        check_eq("rst_dac_n", dac_n, 131071);
        check_eq("rst_dtc", dtc_code, 512);
        tick();
        tick();
        check_eq("rst_hold_dlf", dlf_out, 131072);
        check_eq("rst_hold_dtc", dtc_code, 512);

        // Single error step
        err    = 7'sd0;
        qnc    = 10'sd0;
        freeze = 1'b0;
        rst    = 1'b1;
        err    = 7'sd1;
        tick();
        check_eq("step_dlf0", dlf_out, 131140);
        check_eq("step_dac_p0", dac_p, 131140);
        check_eq("step_dac_n0", dac_n, 131003);
        err = 7'sd0;
        tick();
        check_eq("step_dlf1", dlf_out, 131076);
        check_eq("step_dac_n1", dac_n, 131067);
        tick();
        tick();
        check_eq("step_dlf_hold", dlf_out, 131076);
        check_eq("dac_sum", longint'(dac_p) + longint'(dac_n), 262143);

        // Freeze: proportional term only
        do_reset();
        freeze = 1'b1;
        err    = -7'sd2;
        tick();
        check_eq("frz_dlf0", dlf_out, 130944);
        tick();
        tick();
        check_eq("frz_dlf2", dlf_out, 130944);
        freeze = 1'b0;
        err    = 7'sd0;
        tick();
        check_eq("frz_no_integ", dlf_out, 131072);

        // Upper saturation and integrator clamp
        do_reset();
        err = 7'sd63;
        n   = 0;
        while (dlf_out != 18'd262143 && n < 700) begin
            tick();
            n++;
        end
        check_eq("sat_hi_cycles", n, 505);
        repeat (30) tick();
        check_eq("sat_hi_hold", dlf_out, 262143);
        err = -7'sd63;
        tick();
        check_eq("sat_hi_release", dlf_out, 257859);
        err = 7'sd0;
        tick();
        check_eq("sat_hi_acc", dlf_out, 261891);

        // Lower saturation and integrator clamp
        do_reset();
        err = -7'sd63;
        n   = 0;
        while (dlf_out != 18'd0 && n < 700) begin
            tick();
            n++;
        end
        check_eq("sat_lo_cycles", n, 505);
        repeat (30) tick();
        err = 7'sd0;
        tick();
        check_eq("sat_lo_acc", dlf_out, 0);
        err = 7'sd63;
        tick();
        check_eq("sat_lo_release", dlf_out, 4284);

        // DTC offset-binary conversion
        do_reset();
        err = 7'sd0;
        qnc = 10'sh200;
        tick();
`ifdef PLL_BACKEND_DTC_EN
        check_eq("dtc_min", dtc_code, 0);
`else
        check_eq("dtc_min", dtc_code, 512);
`endif
        qnc = 10'sd0;
        tick();
        check_eq("dtc_zero", dtc_code, 512);
        qnc = 10'sd511;
        tick();
`ifdef PLL_BACKEND_DTC_EN
        check_eq("dtc_max", dtc_code, 1023);
`else
        check_eq("dtc_max", dtc_code, 512);
`endif

        // Reset asserted mid-operation
        do_reset();
        err = 7'sd63;
        n   = 0;
        while (dlf_out < 18'd200000 && n < 700) begin
            tick();
            n++;
        end
        check_eq("mid_reached", longint'(dlf_out >= 18'd200000), 1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_dlf", dlf_out, 131072);
        check_eq("mid_rst_dac_n", dac_n, 131071);
        check_eq("mid_rst_dtc", dtc_code, 512);
        tick();
        check_eq("mid_rst_hold", dlf_out, 131072);
        rst = 1'b1;
        err = 7'sd0;
        tick();
        check_eq("mid_resume", dlf_out, 131072);
        tick();
        check_eq("mid_resume2", dlf_out, 131072);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
